// File: rtl/fft8_pipe_if.sv
// Frame handshake bundle for fft8_pipe: input frame with per-frame inverse flag,
// output frame with downstream backpressure.
interface fft8_pipe_if #(
    parameter int DW = 16
);
    logic              in_valid;
    logic              in_ready;
    logic              inv;
    logic [16*DW-1:0]  x_in;
    logic              out_valid;
    logic              out_ready;
    logic [16*DW-1:0]  y_out;

    modport master (
        output in_valid, inv, x_in, out_ready,
        input  in_ready, out_valid, y_out
    );

    modport slave (
        input  in_valid, inv, x_in, out_ready,
        output in_ready, out_valid, y_out
    );
endinterface

// File: rtl/fft8_pipe.sv
// Pipelined 8-point radix-2 DIT FFT/IFFT, one frame per cycle, natural-order output.
// Optional per-stage 1/2 scaling: define FFT8_STAGE_SCALE_EN.
module fft8_pipe #(
    parameter int DW   = 16,
    parameter int TW   = 16,
    parameter int FRAC = 12
) (
    input  logic       clk,
    input  logic       reset_n,
    fft8_pipe_if.slave bus
);
    localparam int PW = DW + TW + 1;
    localparam int CI = int'(0.7071 * (2.0 ** FRAC));
    localparam logic signed [TW-1:0] CP   = TW'(CI);
    localparam logic signed [TW-1:0] CN   = TW'(-CI);
    localparam logic signed [PW-1:0] HALF = PW'(1) <<< (FRAC - 1);

    typedef logic signed [DW-1:0] samp_t;

    function automatic samp_t bfly_out(input logic signed [DW:0] s);
`ifdef FFT8_STAGE_SCALE_EN
        logic signed [DW+1:0] t;
        t = ((DW+2)'(s) + (DW+2)'(1)) >>> 1;
        return samp_t'(t);
`else
        return samp_t'(s);
`endif
    endfunction

    function automatic logic signed [DW:0] addw(input samp_t a, input samp_t b);
        return (DW+1)'(a) + (DW+1)'(b);
    endfunction

    function automatic logic signed [DW:0] subw(input samp_t a, input samp_t b);
        return (DW+1)'(a) - (DW+1)'(b);
    endfunction

    function automatic samp_t rnd(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] t;
        t = (p + HALF) >>> FRAC;
        return samp_t'(t);
    endfunction

    // Returns {re, im}; products are exact at PW bits, one rounding per component.
    function automatic logic [2*DW-1:0] cmul(input samp_t ar, input samp_t ai,
                                             input logic signed [TW-1:0] wr,
                                             input logic signed [TW-1:0] wi);
        logic signed [PW-1:0] pr;
        logic signed [PW-1:0] pi;
        pr = PW'(ar) * PW'(wr) - PW'(ai) * PW'(wi);
        pi = PW'(ar) * PW'(wi) + PW'(ai) * PW'(wr);
        return {rnd(pr), rnd(pi)};
    endfunction

    // Multiply by -j (forward) or +j (inverse); returns {re, im}.
    function automatic logic [2*DW-1:0] rot_w2(input samp_t r, input samp_t i, input logic inv);
        return inv ? {samp_t'(-i), r} : {i, samp_t'(-r)};
    endfunction

    function automatic int brev(input int k);
        logic [2:0] b;
        b = 3'(k);
        return int'({b[0], b[1], b[2]});
    endfunction

    logic  stall, en, accept;
    logic  vld_p0, vld_p1, vld_p2, vld_p3;
    logic  inv_p0, inv_p1;
    samp_t re_in [8], im_in [8];
    samp_t re_p0 [8], im_p0 [8];
    samp_t re_s1 [8], im_s1 [8];
    samp_t re_p1 [8], im_p1 [8];
    samp_t bre   [8], bim   [8];
    samp_t mre   [8], mim   [8];
    samp_t re_s2 [8], im_s2 [8];
    samp_t re_p2 [8], im_p2 [8];
    samp_t re_s3 [8], im_s3 [8];
    samp_t re_p3 [8], im_p3 [8];

    assign stall         = vld_p3 & ~bus.out_ready;
    assign en            = ~stall;
    assign accept        = bus.in_valid & en;
    assign bus.in_ready  = en;
    assign bus.out_valid = vld_p3;

    for (genvar k = 0; k < 8; k++) begin : g_io
        assign re_in[k] = samp_t'(bus.x_in[2*brev(k)*DW +: DW]);
        assign im_in[k] = samp_t'(bus.x_in[(2*brev(k)+1)*DW +: DW]);
        assign bus.y_out[2*k*DW +: DW]     = re_p3[k];
        assign bus.y_out[(2*k+1)*DW +: DW] = im_p3[k];
    end

    // S0 -> S1: span-1 butterflies, no twiddle
    always_comb begin
        for (int g = 0; g < 4; g++) begin
            re_s1[2*g]   = bfly_out(addw(re_p0[2*g], re_p0[2*g+1]));
            im_s1[2*g]   = bfly_out(addw(im_p0[2*g], im_p0[2*g+1]));
            re_s1[2*g+1] = bfly_out(subw(re_p0[2*g], re_p0[2*g+1]));
            im_s1[2*g+1] = bfly_out(subw(im_p0[2*g], im_p0[2*g+1]));
        end
    end

    // S1 -> S2: W2 on odd lower legs, span-2 butterflies, then W1/W2/W3 for the last stage
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            bre[k] = re_p1[k];
            bim[k] = im_p1[k];
        end
        {bre[3], bim[3]} = rot_w2(re_p1[3], im_p1[3], inv_p1);
        {bre[7], bim[7]} = rot_w2(re_p1[7], im_p1[7], inv_p1);
        for (int j = 0; j < 4; j++) begin
            mre[(j/2)*4 + j%2]     = bfly_out(addw(bre[(j/2)*4 + j%2], bre[(j/2)*4 + j%2 + 2]));
            mim[(j/2)*4 + j%2]     = bfly_out(addw(bim[(j/2)*4 + j%2], bim[(j/2)*4 + j%2 + 2]));
            mre[(j/2)*4 + j%2 + 2] = bfly_out(subw(bre[(j/2)*4 + j%2], bre[(j/2)*4 + j%2 + 2]));
            mim[(j/2)*4 + j%2 + 2] = bfly_out(subw(bim[(j/2)*4 + j%2], bim[(j/2)*4 + j%2 + 2]));
        end
        for (int k = 0; k < 8; k++) begin
            re_s2[k] = mre[k];
            im_s2[k] = mim[k];
        end
        {re_s2[5], im_s2[5]} = cmul(mre[5], mim[5], CP, inv_p1 ? CP : CN);
        {re_s2[6], im_s2[6]} = rot_w2(mre[6], mim[6], inv_p1);
        {re_s2[7], im_s2[7]} = cmul(mre[7], mim[7], CN, inv_p1 ? CP : CN);
    end

    // S2 -> S3: span-4 butterflies produce natural-order bins
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            re_s3[k]   = bfly_out(addw(re_p2[k], re_p2[k+4]));
            im_s3[k]   = bfly_out(addw(im_p2[k], im_p2[k+4]));
            re_s3[k+4] = bfly_out(subw(re_p2[k], re_p2[k+4]));
            im_s3[k+4] = bfly_out(subw(im_p2[k], im_p2[k+4]));
        end
    end

    // Global enable freezes every stage while the output is stalled; bubbles never overwrite data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
            inv_p0 <= 1'b0;
            inv_p1 <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                re_p0[k] <= '0;
                im_p0[k] <= '0;
                re_p1[k] <= '0;
                im_p1[k] <= '0;
                re_p2[k] <= '0;
                im_p2[k] <= '0;
                re_p3[k] <= '0;
                im_p3[k] <= '0;
            end
        end else if (en) begin
            vld_p0 <= accept;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
            if (accept) begin
                inv_p0 <= bus.inv;
                for (int k = 0; k < 8; k++) begin
                    re_p0[k] <= re_in[k];
                    im_p0[k] <= im_in[k];
                end
            end
            if (vld_p0) begin
                inv_p1 <= inv_p0;
                for (int k = 0; k < 8; k++) begin
                    re_p1[k] <= re_s1[k];
                    im_p1[k] <= im_s1[k];
                end
            end
            if (vld_p1) begin
                for (int k = 0; k < 8; k++) begin
                    re_p2[k] <= re_s2[k];
                    im_p2[k] <= im_s2[k];
                end
            end
            if (vld_p2) begin
                for (int k = 0; k < 8; k++) begin
                    re_p3[k] <= re_s3[k];
                    im_p3[k] <= im_s3[k];
                end
            end
        end
    end
endmodule
